// File: rtl/mprj_pad_cfg_sequencer_pkg.sv
// Shared types and constants for the GPIO pad configuration sequencer.
// Field offsets describe one pad's control word as latched by its control block.
package mprj_pad_cfg_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOAD, DONE} seq_state_t;

   typedef enum int unsigned {
      CFG_MGMT_EN    = 0,
      CFG_OEB        = 1,
      CFG_HOLD       = 2,
      CFG_INP_DIS    = 3,
      CFG_IB_MODE    = 4,
      CFG_ANALOG_EN  = 5,
      CFG_ANALOG_SEL = 6,
      CFG_ANALOG_POL = 7,
      CFG_SLOW       = 8,
      CFG_VTRIP      = 9,
      CFG_DM0        = 10,
      CFG_DM1        = 11,
      CFG_DM2        = 12
   } pad_cfg_field_e;

   localparam int PAD_CFG_BITS = 13;

   // Management-owned output pad, dm=001: value 13'h0403.
   localparam logic [PAD_CFG_BITS-1:0] PAD_DEFAULT_CFG =
      (PAD_CFG_BITS'(1) << CFG_MGMT_EN) |
      (PAD_CFG_BITS'(1) << CFG_OEB)     |
      (PAD_CFG_BITS'(1) << CFG_DM0);

endpackage

// File: rtl/mprj_pad_cfg_sequencer_if.sv
// Housekeeping-side shadow register bus of the pad configuration sequencer.
interface mprj_pad_cfg_sequencer_if #(
   parameter int AW       = 6,
   parameter int CFG_BITS = 13
);
   logic                cfg_we;
   logic [AW-1:0]       cfg_addr;
   logic [CFG_BITS-1:0] cfg_wdata;
   logic [CFG_BITS-1:0] cfg_rdata;
   logic                cfg_err;

   modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_rdata, cfg_err);
   modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_rdata, cfg_err);
endinterface

// File: rtl/mprj_pad_cfg_sequencer_shadow.sv
// Per-pad shadow configuration words. Writes are refused while a load
// sequence runs or when the index is past the last pad.
module mprj_pad_cfg_shadow
   import mprj_pad_cfg_pkg::*;
#(
   parameter int                  NUM_PADS    = 38,
   parameter int                  CFG_BITS    = 13,
   parameter int                  AW          = $clog2(NUM_PADS),
   parameter logic [CFG_BITS-1:0] DEFAULT_CFG = CFG_BITS'(PAD_DEFAULT_CFG)
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                busy,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_wdata,
   output logic [CFG_BITS-1:0] cfg_rdata,
   output logic                cfg_err,
   output logic                wr_ok,
   input  logic [AW-1:0]       seq_addr,
   output logic [CFG_BITS-1:0] seq_word
);

   logic [CFG_BITS-1:0] mem [NUM_PADS];
   logic                addr_ok;

   assign addr_ok = 32'(cfg_addr) < NUM_PADS;
   assign wr_ok   = cfg_we && !busy && addr_ok;

   always_comb begin
      cfg_rdata = '0;
      seq_word  = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (32'(cfg_addr) == i) cfg_rdata = mem[i];
         if (32'(seq_addr) == i) seq_word  = mem[i];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cfg_err <= 1'b0;
         for (int i = 0; i < NUM_PADS; i++) mem[i] <= DEFAULT_CFG;
      end else begin
         cfg_err <= cfg_we && !wr_ok;
         for (int i = 0; i < NUM_PADS; i++) begin
            if (wr_ok && 32'(cfg_addr) == i) mem[i] <= cfg_wdata;
         end
      end
   end

endmodule

// File: rtl/mprj_pad_cfg_sequencer.sv
// Shifts every pad's shadow word down the pad control chain, last pad first,
// MSB first, then strobes serial_load so all pads change mode together.
//
// state | meaning
// IDLE  | waiting for start or a porb_l rising edge
// SETUP | serial_data presents the current bit, serial_clock low, HALF cycles
// HIGH  | serial_clock high, HALF cycles; then next bit or LOAD
// LOAD  | serial_load high, HALF cycles
// DONE  | one-cycle done pulse, back to IDLE
module mprj_pad_cfg_sequencer
   import mprj_pad_cfg_pkg::*;
#(
   parameter int                  NUM_PADS    = 38,
   parameter int                  CFG_BITS    = 13,
   parameter int                  DIV_W       = 8,
   parameter logic [CFG_BITS-1:0] DEFAULT_CFG = CFG_BITS'(PAD_DEFAULT_CFG),
   parameter int                  AW          = $clog2(NUM_PADS)
) (
   input  logic                   clock,
   input  logic                   resetn,
   mprj_pad_cfg_sequencer_if.slave cfg,
   input  logic                   start,
   input  logic                   porb_l,
   input  logic [DIV_W-1:0]       clk_div,
   output logic                   busy,
   output logic                   done,
   output logic                   serial_clock,
   output logic                   serial_data,
   output logic                   serial_load,
   output logic                   serial_resetn
);

   localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

   seq_state_t          state;
   logic [DIV_W-1:0]    half_r;
   logic [DIV_W-1:0]    hcnt;
   logic [DIV_W-1:0]    half_sel;
   logic [AW-1:0]       pad_idx;
   logic [AW-1:0]       nxt_pad;
   logic [AW-1:0]       seq_addr;
   logic [BW-1:0]       bit_idx;
   logic [BW-1:0]       nxt_bit;
   logic [CFG_BITS-1:0] seq_word;
   logic [CFG_BITS-1:0] first_word;
   logic                last_bit;
   logic                wr_ok;
   logic                porb_q;
   logic                porb_rise;
   logic                run_pend;
   logic                trigger;

   mprj_pad_cfg_shadow #(
      .NUM_PADS    (NUM_PADS),
      .CFG_BITS    (CFG_BITS),
      .AW          (AW),
      .DEFAULT_CFG (DEFAULT_CFG)
   ) u_shadow (
      .clock     (clock),
      .resetn    (resetn),
      .busy      (busy),
      .cfg_we    (cfg.cfg_we),
      .cfg_addr  (cfg.cfg_addr),
      .cfg_wdata (cfg.cfg_wdata),
      .cfg_rdata (cfg.cfg_rdata),
      .cfg_err   (cfg.cfg_err),
      .wr_ok     (wr_ok),
      .seq_addr  (seq_addr),
      .seq_word  (seq_word)
   );

   assign porb_rise = porb_l && !porb_q;
   assign trigger   = start || porb_rise || run_pend;
   assign half_sel  = (clk_div == '0) ? DIV_W'(1) : clk_div;

   always_comb begin
      last_bit = (pad_idx == '0) && (bit_idx == '0);
      if (bit_idx == '0) begin
         nxt_bit = BW'(CFG_BITS - 1);
         nxt_pad = pad_idx - AW'(1);
      end else begin
         nxt_bit = bit_idx - BW'(1);
         nxt_pad = pad_idx;
      end
      seq_addr = (state == IDLE) ? AW'(NUM_PADS - 1) : nxt_pad;
      // A write landing on the first-shifted pad in the trigger cycle must be
      // shifted out, so bypass the not-yet-updated shadow.
      if (wr_ok && (32'(cfg.cfg_addr) == NUM_PADS - 1)) first_word = cfg.cfg_wdata;
      else                                              first_word = seq_word;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         half_r        <= '0;
         hcnt          <= '0;
         pad_idx       <= '0;
         bit_idx       <= '0;
         porb_q        <= 1'b0;
         run_pend      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         serial_clock  <= 1'b0;
         serial_data   <= 1'b0;
         serial_load   <= 1'b0;
         serial_resetn <= 1'b0;
      end else begin
         serial_resetn <= 1'b1;
         porb_q        <= porb_l;
         done          <= 1'b0;
         if (porb_rise) run_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (trigger) begin
                  run_pend     <= 1'b0;
                  half_r       <= half_sel;
                  hcnt         <= half_sel - DIV_W'(1);
                  pad_idx      <= AW'(NUM_PADS - 1);
                  bit_idx      <= BW'(CFG_BITS - 1);
                  serial_data  <= first_word[CFG_BITS-1];
                  serial_clock <= 1'b0;
                  busy         <= 1'b1;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               if (hcnt == '0) begin
                  serial_clock <= 1'b1;
                  hcnt         <= half_r - DIV_W'(1);
                  state        <= HIGH;
               end else begin
                  hcnt <= hcnt - DIV_W'(1);
               end
            end
            HIGH: begin
               if (hcnt == '0) begin
                  serial_clock <= 1'b0;
                  hcnt         <= half_r - DIV_W'(1);
                  if (last_bit) begin
                     serial_data <= 1'b0;
                     serial_load <= 1'b1;
                     state       <= LOAD;
                  end else begin
                     pad_idx     <= nxt_pad;
                     bit_idx     <= nxt_bit;
                     serial_data <= seq_word[nxt_bit];
                     state       <= SETUP;
                  end
               end else begin
                  hcnt <= hcnt - DIV_W'(1);
               end
            end
            LOAD: begin
               if (hcnt == '0) begin
                  serial_load <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  hcnt <= hcnt - DIV_W'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
